rs_enc_stats_log_responder: RTL and testbench
=============================================

// Module: rs_enc_stats_log_responder
// PURPOSE
// Stats-side responder for the RS-encode UDP app. Keeps running counters (cycle timestamp, bytes sent,
// requests done), snapshots them every RECORD_PERIOD cycles into a circular log, and serves
// client read requests (req_addr -> {resp_addr, rs_enc_stats_struct}) over valid/ready.
// Sits between the encoder datapath (event inputs) and the stats NoC request/response adapter.
// PARAMETERS
// RECORD_PERIOD     125000000  cycles between snapshots (>=2)
// STATS_DEPTH_LOG2  8          log2 of log depth (256 entries)
// BYTES_INCR_W      16         width of per-event byte increment
// PORTS
// clk                   in   1                      clock
// rst                   in   1                      synchronous, active-high reset
// log_en                in   1                      1 = period counter runs and snapshots are written
// bytes_sent_val        in   1                      pulse: add bytes_sent_incr to bytes_sent
// bytes_sent_incr       in   BYTES_INCR_W           byte increment
// req_done              in   1                      pulse: reqs_done += 1
// stats_req_val         in   1                      request valid
// stats_req             in   RS_ENC_STATS_REQ_STRUCT_W  rs_enc_stats_req_struct
// stats_req_rdy         out  1                      request accepted when val&rdy
// stats_resp_val        out  1                      response valid
// stats_resp            out  RS_ENC_STATS_RESP_W    {resp_addr[15:0], rs_enc_stats_struct}
// stats_resp_rdy        in   1                      response consumed when val&rdy
// num_entries           out  STATS_DEPTH_LOG2+1     valid entries in log, saturates at 2^STATS_DEPTH_LOG2
// BEHAVIOUR
// - Reset: all counters, wr_ptr, period counter, num_entries = 0; FSM=IDLE; stats_req_rdy=0 in reset
//   cycle, 1 the cycle after; stats_resp_val=0; stats_resp=0. Log RAM contents not reset.
// - timestamp: 64b free-running cycle count, increments every cycle regardless of log_en, wraps mod 2^64.
// - bytes_sent: 64b, += zero-extended bytes_sent_incr when bytes_sent_val; reqs_done: 64b, +1 on req_done;
//   both wrap mod 2^64. Both events in same cycle: both applied.
// - Period counter: if log_en, counts 0..RECORD_PERIOD-1 then wraps; when log_en=0 it is held at 0.
//   At count==RECORD_PERIOD-1 (log_en=1): write {timestamp,bytes_sent,reqs_done} (values registered
//   BEFORE this cycle's increments) to log[wr_ptr]; wr_ptr += 1 mod depth; num_entries += 1, saturating.
//   Wrap: after depth writes, oldest entry at index wr_ptr is overwritten; addressing is absolute index.
// - Request FSM: IDLE (stats_req_rdy=1) -> on val&rdy latch req_addr, issue RAM read -> RD (1 cycle,
//   rdy=0) -> RESP (stats_resp_val=1, output held stable) -> on stats_resp_rdy -> IDLE.
//   Accept-to-resp_val latency = 2 cycles; minimum 3 cycles per request; no back-to-back acceptance.
// - Range check at acceptance: req_addr >= num_entries (incl. any addr >= depth) -> payload all zero,
//   resp_addr = req_addr. In range -> payload = log[req_addr[STATS_DEPTH_LOG2-1:0]].
// - Snapshot write to same index as an in-flight read: read returns old contents (read-first); if the
//   index was empty at acceptance the response is zero.
// - rst mid-request: FSM to IDLE, pending response dropped, stats_resp_val=0 next cycle.
// STRUCTURE
// - rs_encode_stats_pkg holds TIMESTAMP_W/BYTES_SENT_W/REQS_DONE_W, STATS_DEPTH_LOG2, RECORD_PERIOD,
//   rs_enc_stats_struct, rs_enc_stats_req_struct, RS_ENC_STATS_RESP_W, CLIENT_ADDR_W; FSM state enum local.
// - One sub-module: rs_enc_stats_log_ram, 1R1W synchronous RAM, width RS_ENC_STATS_STRUCT_W,
//   depth 2^STATS_DEPTH_LOG2, 1-cycle read latency, read-first on address collision.
// TESTING (RECORD_PERIOD=10, STATS_DEPTH_LOG2=2 unless noted)
// - Reset, log_en=1, idle 25 cycles -> num_entries=2; req addr 0 -> resp {0x0000, ts=9, bytes=0, reqs=0}
//   with stats_resp_val exactly 2 cycles after acceptance.
// - bytes_sent_val with incr=100 at cycles 3,4 and req_done at 4 -> entry 0 = {ts=9, bytes=200, reqs=1};
//   events in snapshot cycle 19 excluded from entry 1, included in entry 2.
// - Run 60 cycles -> num_entries=4 (saturated); entries 0,1 hold ts=49,59; entries 2,3 hold ts=29,39.
// - req addr 3 when num_entries=2 -> resp {0x0003, 0}; req addr 0x0100 -> resp {0x0100, 0}.
// - Hold stats_resp_rdy=0 for 5 cycles -> stats_resp stable, stats_req_rdy=0 throughout; new req
//   accepted only the cycle after handshake.
// - log_en=0 for 30 cycles -> no writes, num_entries unchanged; assert rst during RESP -> resp_val=0 next cycle.

Source files
------------

// File: rtl/rs_encode_stats_pkg.sv
// Shared types and default parameters for the RS-encode stats logging block.
// The response word is {resp_addr, rs_enc_stats_struct}, most significant field first.
package rs_encode_stats_pkg;

    localparam int TIMESTAMP_W      = 64;
    localparam int BYTES_SENT_W     = 64;
    localparam int REQS_DONE_W      = 64;
    localparam int STATS_DEPTH_LOG2 = 8;
    localparam int RECORD_PERIOD    = 125000000;
    localparam int CLIENT_ADDR_W    = 16;

    typedef struct packed {
        logic [TIMESTAMP_W-1:0]  timestamp;
        logic [BYTES_SENT_W-1:0] bytes_sent;
        logic [REQS_DONE_W-1:0]  reqs_done;
    } rs_enc_stats_struct;

    localparam int RS_ENC_STATS_STRUCT_W = $bits(rs_enc_stats_struct);

    typedef struct packed {
        logic [CLIENT_ADDR_W-1:0] req_addr;
    } rs_enc_stats_req_struct;

    localparam int RS_ENC_STATS_REQ_STRUCT_W = $bits(rs_enc_stats_req_struct);

    typedef struct packed {
        logic [CLIENT_ADDR_W-1:0] resp_addr;
        rs_enc_stats_struct       stats;
    } rs_enc_stats_resp_struct;

    localparam int RS_ENC_STATS_RESP_W = $bits(rs_enc_stats_resp_struct);

    // Out-of-range reads answer with the echoed address and an all-zero payload.
    function automatic rs_enc_stats_resp_struct make_resp(
        input logic [CLIENT_ADDR_W-1:0] addr,
        input rs_enc_stats_struct       stats,
        input logic                     in_range
    );
        rs_enc_stats_resp_struct resp;
        resp.resp_addr = addr;
        if (in_range) begin
            resp.stats = stats;
        end else begin
            resp.stats = '0;
        end
        return resp;
    endfunction

endpackage

// File: rtl/rs_enc_stats_log_ram.sv
// 1R1W synchronous log RAM, one-cycle read latency, read-first when a write
// and a read hit the same index in the same cycle. Contents are not reset.
module rs_enc_stats_log_ram #(
    parameter int WIDTH  = rs_encode_stats_pkg::RS_ENC_STATS_STRUCT_W,
    parameter int ADDR_W = rs_encode_stats_pkg::STATS_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [2**ADDR_W];
    logic [WIDTH-1:0] rdata_r;

    // Storage write and registered read; the read samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rs_enc_stats_log_responder.sv
// Running stats counters, periodic snapshots into a circular log, and a
// valid/ready read port that serves one log entry per request.
module rs_enc_stats_log_responder #(
    parameter int RECORD_PERIOD    = rs_encode_stats_pkg::RECORD_PERIOD,
    parameter int STATS_DEPTH_LOG2 = rs_encode_stats_pkg::STATS_DEPTH_LOG2,
    parameter int BYTES_INCR_W     = 16
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      log_en,
    input  logic                                                      bytes_sent_val,
    input  logic [BYTES_INCR_W-1:0]                                   bytes_sent_incr,
    input  logic                                                      req_done,
    input  logic                                                      stats_req_val,
    input  logic [rs_encode_stats_pkg::RS_ENC_STATS_REQ_STRUCT_W-1:0] stats_req,
    output logic                                                      stats_req_rdy,
    output logic                                                      stats_resp_val,
    output logic [rs_encode_stats_pkg::RS_ENC_STATS_RESP_W-1:0]       stats_resp,
    input  logic                                                      stats_resp_rdy,
    output logic [STATS_DEPTH_LOG2:0]                                 num_entries
);

    import rs_encode_stats_pkg::*;

    localparam int                    PERIOD_W    = $clog2(RECORD_PERIOD);
    localparam logic [PERIOD_W-1:0]   PERIOD_LAST = PERIOD_W'(RECORD_PERIOD - 1);
    localparam logic [STATS_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {STATS_DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [TIMESTAMP_W-1:0]      timestamp_r;
    logic [BYTES_SENT_W-1:0]     bytes_sent_r;
    logic [REQS_DONE_W-1:0]      reqs_done_r;
    logic [PERIOD_W-1:0]         period_cnt_r;
    logic [STATS_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [STATS_DEPTH_LOG2:0]   num_entries_r;
    logic                        snap_s;
    rs_enc_stats_struct          snap_data_s;

    logic [1:0]                  state_r;
    logic [1:0]                  state_nxt_s;
    logic                        accept_s;
    logic                        stats_req_rdy_r;
    logic                        stats_resp_val_r;
    rs_enc_stats_resp_struct     stats_resp_r;
    rs_enc_stats_resp_struct     resp_nxt_s;
    rs_enc_stats_req_struct      req_s;
    logic [CLIENT_ADDR_W-1:0]    req_addr_r;
    logic                        in_range_r;
    logic [RS_ENC_STATS_STRUCT_W-1:0] ram_rdata_s;

    assign req_s       = stats_req;
    assign snap_s      = log_en && (period_cnt_r == PERIOD_LAST);
    assign snap_data_s = '{timestamp: timestamp_r, bytes_sent: bytes_sent_r, reqs_done: reqs_done_r};

    // Free-running timestamp and event accumulators; both events in one cycle both apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            timestamp_r  <= '0;
            bytes_sent_r <= '0;
            reqs_done_r  <= '0;
        end else begin
            timestamp_r <= timestamp_r + 64'd1;
            if (bytes_sent_val) begin
                bytes_sent_r <= bytes_sent_r + BYTES_SENT_W'(bytes_sent_incr);
            end
            if (req_done) begin
                reqs_done_r <= reqs_done_r + 64'd1;
            end
        end
    end

    // Snapshot cadence, log write pointer and saturating fill count.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_r  <= '0;
            wr_ptr_r      <= '0;
            num_entries_r <= '0;
        end else begin
            if (!log_en || snap_s) begin
                period_cnt_r <= '0;
            end else begin
                period_cnt_r <= period_cnt_r + PERIOD_W'(1);
            end
            if (snap_s) begin
                wr_ptr_r <= wr_ptr_r + STATS_DEPTH_LOG2'(1);
                if (num_entries_r != FULL_COUNT) begin
                    num_entries_r <= num_entries_r + (STATS_DEPTH_LOG2 + 1)'(1);
                end
            end
        end
    end

    rs_enc_stats_log_ram #(
        .WIDTH  (RS_ENC_STATS_STRUCT_W),
        .ADDR_W (STATS_DEPTH_LOG2)
    ) u_log_ram (
        .clk   (clk),
        .we    (snap_s),
        .waddr (wr_ptr_r),
        .wdata (snap_data_s),
        .re    (accept_s),
        .raddr (req_s.req_addr[STATS_DEPTH_LOG2-1:0]),
        .rdata (ram_rdata_s)
    );

    // Request FSM next state; acceptance only from IDLE with ready already asserted.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stats_req_val && stats_req_rdy_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (stats_resp_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Response word assembled from the RAM output using the range decision taken at acceptance.
    always_comb begin
        resp_nxt_s = make_resp(req_addr_r, rs_enc_stats_struct'(ram_rdata_s), in_range_r);
    end

    // FSM state, registered ready, and the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            stats_req_rdy_r <= 1'b0;
            req_addr_r      <= '0;
            in_range_r      <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            stats_req_rdy_r <= (state_nxt_s == ST_IDLE);
            if (accept_s) begin
                req_addr_r <= req_s.req_addr;
                in_range_r <= (32'(req_s.req_addr) < 32'(num_entries_r));
            end
        end
    end

    // Response register: loaded once from RD, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stats_resp_val_r <= 1'b0;
            stats_resp_r     <= '0;
        end else begin
            case (state_r)
                ST_RD: begin
                    stats_resp_val_r <= 1'b1;
                    stats_resp_r     <= resp_nxt_s;
                end
                ST_RESP: begin
                    if (stats_resp_rdy) begin
                        stats_resp_val_r <= 1'b0;
                    end
                end
                default: begin
                    stats_resp_val_r <= 1'b0;
                end
            endcase
        end
    end

    assign stats_req_rdy  = stats_req_rdy_r;
    assign stats_resp_val = stats_resp_val_r;
    assign stats_resp     = stats_resp_r;
    assign num_entries    = num_entries_r;

endmodule

// File: tb/tb_rs_enc_stats_log_responder.sv
// Bench for rs_enc_stats_log_responder with a short record period and a 4-entry log.
// A cycle-level reference keeps the counters and log as plain arrays and answers reads.
module tb_rs_enc_stats_log_responder;

    import rs_encode_stats_pkg::*;

    localparam int RP    = 10;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         log_en = 1'b0;
    logic         bytes_sent_val;
    logic [15:0]  bytes_sent_incr;
    logic         req_done;
    logic         stats_req_val = 1'b0;
    logic [15:0]  stats_req = 16'h0000;
    logic         stats_req_rdy;
    logic         stats_resp_val;
    logic [207:0] stats_resp;
    logic         stats_resp_rdy = 1'b0;
    logic [DL2:0] num_entries;

    int n_checks = 0;
    int n_fail   = 0;
    int ev_mode  = 0;
    logic [207:0] last_resp;

    // reference state
    logic [63:0]  m_ts, m_bytes, m_reqs;
    int           m_phase, m_wr, m_count;
    logic [191:0] m_log [DEPTH];

    rs_enc_stats_log_responder #(
        .RECORD_PERIOD    (RP),
        .STATS_DEPTH_LOG2 (DL2),
        .BYTES_INCR_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .log_en          (log_en),
        .bytes_sent_val  (bytes_sent_val),
        .bytes_sent_incr (bytes_sent_incr),
        .req_done        (req_done),
        .stats_req_val   (stats_req_val),
        .stats_req       (stats_req),
        .stats_req_rdy   (stats_req_rdy),
        .stats_resp_val  (stats_resp_val),
        .stats_resp      (stats_resp),
        .stats_resp_rdy  (stats_resp_rdy),
        .num_entries     (num_entries)
    );

    always #5 clk = ~clk;

    // reference: counters, snapshot every RP enabled cycles, circular log with saturating fill
    always @(posedge clk) begin
        if (rst) begin
            m_ts <= 64'd0; m_bytes <= 64'd0; m_reqs <= 64'd0;
            m_phase <= 0; m_wr <= 0; m_count <= 0;
        end else begin
            m_ts <= m_ts + 64'd1;
            if (bytes_sent_val) m_bytes <= m_bytes + {48'd0, bytes_sent_incr};
            if (req_done) m_reqs <= m_reqs + 64'd1;
            if (log_en) begin
                if (m_phase == RP - 1) begin
                    m_log[m_wr] <= {m_ts, m_bytes, m_reqs};
                    m_wr        <= (m_wr + 1) % DEPTH;
                    m_count     <= (m_count < DEPTH) ? m_count + 1 : DEPTH;
                    m_phase     <= 0;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    function automatic logic [207:0] model_resp(input logic [15:0] addr);
        if (int'(addr) < m_count) return {addr, m_log[int'(addr) % DEPTH]};
        return {addr, 192'd0};
    endfunction

    // event stimulus: none, the fixed pattern around cycles 3/4/19, or random
    initial begin
        bytes_sent_val = 1'b0; bytes_sent_incr = 16'd0; req_done = 1'b0;
        forever begin
            @(negedge clk);
            case (ev_mode)
                1: begin
                    bytes_sent_val  = (m_ts == 64'd3) || (m_ts == 64'd4) || (m_ts == 64'd19);
                    bytes_sent_incr = (m_ts == 64'd19) ? 16'd7 : 16'd100;
                    req_done        = (m_ts == 64'd4) || (m_ts == 64'd19);
                end
                2: begin
                    bytes_sent_val  = 1'($urandom_range(0, 1));
                    bytes_sent_incr = 16'($urandom);
                    req_done        = ($urandom_range(0, 2) == 0);
                end
                default: begin
                    bytes_sent_val = 1'b0; bytes_sent_incr = 16'd0; req_done = 1'b0;
                end
            endcase
        end
    end

    task automatic do_request(input logic [15:0] addr, input int hold, input string tag);
        logic [207:0] exp;
        int waited;
        waited = 0;
        while (stats_req_rdy !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (stats_req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_rdy_timeout: got %b want 1", tag, stats_req_rdy);
        end
        exp = model_resp(addr);
        stats_req_val = 1'b1;
        stats_req     = addr;
        @(negedge clk);
        stats_req_val = 1'b0;
        stats_req     = 16'h0000;
        n_checks++;
        if (stats_resp_val !== 1'b0 || stats_req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rd_cycle: resp_val=%b req_rdy=%b want 0/0", tag, stats_resp_val, stats_req_rdy);
        end
        @(negedge clk);
        last_resp = stats_resp;
        n_checks++;
        if (stats_resp_val !== 1'b1 || stats_resp !== exp) begin
            n_fail++;
            $display("FAIL %s resp: val=%b got %h want %h", tag, stats_resp_val, stats_resp, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (stats_resp_val !== 1'b1 || stats_resp !== exp || stats_req_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold%0d: val=%b rdy=%b got %h want %h", tag, h, stats_resp_val,
                         stats_req_rdy, stats_resp, exp);
            end
        end
        stats_resp_rdy = 1'b1;
        @(negedge clk);
        stats_resp_rdy = 1'b0;
        n_checks++;
        if (stats_resp_val !== 1'b0 || stats_req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_handshake: resp_val=%b req_rdy=%b want 0/1", tag, stats_resp_val, stats_req_rdy);
        end
    endtask

    task automatic check_entries(input int want, input string tag);
        n_checks++;
        if (int'(num_entries) !== want || int'(num_entries) !== m_count) begin
            n_fail++;
            $display("FAIL %s num_entries: got %0d want %0d (ref %0d)", tag, num_entries, want, m_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; log_en = 1'b0; ev_mode = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stats_req_rdy !== 1'b0 || stats_resp_val !== 1'b0 || stats_resp !== 208'd0 || num_entries !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b val=%b resp=%h num=%0d want 0/0/0/0",
                     stats_req_rdy, stats_resp_val, stats_resp, num_entries);
        end
    endtask

    task automatic test_snapshot_and_range;
        rst = 1'b0; log_en = 1'b1; ev_mode = 1;
        @(negedge clk);
        n_checks++;
        if (stats_req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdy_after_reset: got %b want 1", stats_req_rdy);
        end
        while (m_ts < 64'd25) @(negedge clk);
        check_entries(2, "after_25");
        do_request(16'h0000, 0, "entry0");
        n_checks++;
        if (last_resp !== {16'h0000, 64'd9, 64'd200, 64'd1}) begin
            n_fail++;
            $display("FAIL entry0_const: got %h", last_resp);
        end
        do_request(16'h0003, 0, "addr3_empty");
        n_checks++;
        if (last_resp !== {16'h0003, 192'd0}) begin
            n_fail++;
            $display("FAIL addr3_const: got %h want zero payload", last_resp);
        end
        do_request(16'h0001, 5, "entry1_hold");
        n_checks++;
        if (last_resp !== {16'h0001, 64'd19, 64'd200, 64'd1}) begin
            n_fail++;
            $display("FAIL entry1_const: got %h", last_resp);
        end
        do_request(16'h0002, 0, "entry2");
        n_checks++;
        if (last_resp !== {16'h0002, 64'd29, 64'd207, 64'd2}) begin
            n_fail++;
            $display("FAIL entry2_const: got %h", last_resp);
        end
        do_request(16'h0100, 0, "addr_0100");
        n_checks++;
        if (last_resp !== {16'h0100, 192'd0}) begin
            n_fail++;
            $display("FAIL addr0100_const: got %h want zero payload", last_resp);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] want_ts [4];
        want_ts[0] = 64'd49; want_ts[1] = 64'd59; want_ts[2] = 64'd29; want_ts[3] = 64'd39;
        ev_mode = 0;
        while (m_ts < 64'd62) @(negedge clk);
        check_entries(4, "saturated");
        for (int a = 0; a < 4; a++) begin
            do_request(16'(a), 0, "wrap_read");
            n_checks++;
            if (last_resp[191:128] !== want_ts[a]) begin
                n_fail++;
                $display("FAIL wrap_ts[%0d]: got %0d want %0d", a, last_resp[191:128], want_ts[a]);
            end
        end
    endtask

    task automatic test_log_en_off;
        logic [63:0] ts_en;
        rst = 1'b1; ev_mode = 0;
        @(negedge clk);
        rst = 1'b0; log_en = 1'b1;
        while (m_ts < 64'd15) @(negedge clk);
        log_en = 1'b0;
        repeat (30) @(negedge clk);
        check_entries(1, "log_en_off");
        ts_en  = m_ts;
        log_en = 1'b1;
        repeat (9) @(negedge clk);
        check_entries(1, "reenable_9");
        repeat (3) @(negedge clk);
        check_entries(2, "reenable_12");
        do_request(16'h0001, 0, "reenable_entry");
        n_checks++;
        if (last_resp[191:128] !== ts_en + 64'd9) begin
            n_fail++;
            $display("FAIL reenable_ts: got %0d want %0d", last_resp[191:128], ts_en + 64'd9);
        end
    endtask

    task automatic test_rst_mid_request;
        stats_req_val = 1'b1; stats_req = 16'h0000;
        @(negedge clk);
        stats_req_val = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stats_resp_val !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: resp_val got %b want 1", stats_resp_val);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stats_resp_val !== 1'b0 || stats_resp !== 208'd0 || stats_req_rdy !== 1'b0 || num_entries !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid: val=%b resp=%h rdy=%b num=%0d want 0/0/0/0",
                     stats_resp_val, stats_resp, stats_req_rdy, num_entries);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stats_req_rdy !== 1'b1 || stats_resp_val !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: rdy=%b val=%b want 1/0", stats_req_rdy, stats_resp_val);
        end
    endtask

    task automatic test_random;
        logic [15:0] addr;
        log_en = 1'b1; ev_mode = 2;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) log_en = ~log_en;
            if ($urandom_range(0, 5) == 0) addr = 16'($urandom_range(4, 65535));
            else addr = 16'($urandom_range(0, 5));
            do_request(addr, $urandom_range(0, 3), "random");
            check_entries(m_count, "random_fill");
        end
        ev_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_snapshot_and_range();
        test_wrap();
        test_log_en_off();
        test_rst_mid_request();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
